// File: rtl/reg_file_rd_pkg.sv
// Shared constants and types for the 8-bit core register file.
// The top and the scoreboard import this package so they agree on widths.
package reg_file_rd_pkg;

  localparam int CORE_DATA_W = 8;
  localparam int CORE_NREG   = 4;
  localparam int CORE_ADDR_W = $clog2(CORE_NREG);

  typedef logic [CORE_ADDR_W-1:0] reg_idx_t;
  typedef logic [CORE_DATA_W-1:0] reg_data_t;

  localparam reg_data_t RESET_VAL = '0;

endpackage : reg_file_rd_pkg

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for the register file: one pending-write bit per register,
// plus the read-after-write hazard test for both source operands.
module reg_scoreboard
  import reg_file_rd_pkg::*;
#(
  parameter int NREG   = CORE_NREG,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_dest_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic [NREG-1:0]   busy_vec_o,
  output logic              haz_rs1_o,
  output logic              haz_rs2_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) begin
      busy_d[wb_addr_i] = 1'b0;
    end
    // Applied after the clear, so a new producer supersedes a retiring one.
    if (issue_en_i) begin
      busy_d[issue_dest_i] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazards use the pre-issue vector: an instruction never waits on itself.
  assign haz_rs1_o = busy_q[rs1_addr_i] && !(wb_en_i && (wb_addr_i == rs1_addr_i));
  assign haz_rs2_o = busy_q[rs2_addr_i] && !(wb_en_i && (wb_addr_i == rs2_addr_i));

  assign busy_vec_o = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_rd.sv
// Register file read side: architectural storage, writeback-to-read bypass,
// registered two-operand read with one-cycle latency, and RAW stall.
module reg_file_rd
  import reg_file_rd_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int NREG   = CORE_NREG,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Rd_Req,
  input  logic [ADDR_W-1:0] Rs1_Addr,
  input  logic [ADDR_W-1:0] Rs2_Addr,
  input  logic              Issue_En,
  input  logic [ADDR_W-1:0] Issue_Dest,
  input  logic              WB_En,
  input  logic [ADDR_W-1:0] WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall,
  output logic              Rd_Valid,
  output logic [DATA_W-1:0] Rs1_Data,
  output logic [DATA_W-1:0] Rs2_Data,
  output logic [NREG-1:0]   Busy_Vec
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              rd_valid_q;
  logic [DATA_W-1:0] rs1_data_q, rs2_data_q;
  logic [DATA_W-1:0] rs1_byp, rs2_byp;
  logic              haz_rs1, haz_rs2;
  logic              accept;

  reg_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (CLK),
    .rst_n        (RST_N),
    .rs1_addr_i   (Rs1_Addr),
    .rs2_addr_i   (Rs2_Addr),
    .issue_en_i   (Issue_En),
    .issue_dest_i (Issue_Dest),
    .wb_en_i      (WB_En),
    .wb_addr_i    (WB_Addr),
    .busy_vec_o   (Busy_Vec),
    .haz_rs1_o    (haz_rs1),
    .haz_rs2_o    (haz_rs2)
  );

  assign Stall  = Rd_Req && (haz_rs1 || haz_rs2);
  assign accept = Rd_Req && !Stall;

  // A writeback landing this cycle is forwarded ahead of the stored copy.
  always_comb begin
    rs1_byp = regs_q[Rs1_Addr];
    rs2_byp = regs_q[Rs2_Addr];
    if (WB_En && (WB_Addr == Rs1_Addr)) begin
      rs1_byp = WB_Data;
    end
    if (WB_En && (WB_Addr == Rs2_Addr)) begin
      rs2_byp = WB_Data;
    end
  end

  // NOTE: the storage array is small and architecturally visible, so it is
  // reset with the rest of the state; larger arrays would normally not be.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_W'(RESET_VAL);
      end
    end else if (WB_En) begin
      regs_q[WB_Addr] <= WB_Data;
    end
  end

  // Operand registers hold their last value when nothing is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid_q <= 1'b0;
      rs1_data_q <= DATA_W'(RESET_VAL);
      rs2_data_q <= DATA_W'(RESET_VAL);
    end else begin
      rd_valid_q <= accept;
      if (accept) begin
        rs1_data_q <= rs1_byp;
        rs2_data_q <= rs2_byp;
      end
    end
  end

  assign Rd_Valid = rd_valid_q;
  assign Rs1_Data = rs1_data_q;
  assign Rs2_Data = rs2_data_q;

endmodule : reg_file_rd

// File: doc/reg_file_rd.md
Name: reg_file_rd

Overview:
- Register-file read side of the 8-bit pipelined core: the consumer counterpart to the enable-gated register write path.
- Holds the architectural registers and accepts writeback writes.
- Serves two source-operand reads per request with a registered 1-cycle latency.
- Tracks pending writes in a busy scoreboard and stalls decode on read-after-write hazards, with writeback-to-read bypass.

Parameters:
- DATA_W, 8, operand/register width in bits
- NREG, 4, number of architectural registers
- ADDR_W, 2, register address width; must equal clog2(NREG)

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- Rd_Req  in  1  decode requests an operand read this cycle
- Rs1_Addr  in  ADDR_W  source 1 register index
- Rs2_Addr  in  ADDR_W  source 2 register index
- Issue_En  in  1  an instruction with a destination is issuing; mark Issue_Dest busy
- Issue_Dest  in  ADDR_W  destination register of the issuing instruction
- WB_En  in  1  writeback write strobe
- WB_Addr  in  ADDR_W  writeback register index
- WB_Data  in  DATA_W  writeback value
- Stall  out  1  combinational; request cannot be accepted this cycle
- Rd_Valid  out  1  registered; Rs1_Data/Rs2_Data valid this cycle
- Rs1_Data  out  DATA_W  registered operand 1
- Rs2_Data  out  DATA_W  registered operand 2
- Busy_Vec  out  NREG  registered scoreboard, bit i set means register i has a write pending

Behaviour:
- Reset:
  - RST_N low asynchronously clears all registers, Busy_Vec, Rd_Valid, Rs1_Data and Rs2_Data to 0.
  - Stall is combinational and evaluates to 0 while Rd_Req is 0.
  - Reset asserted mid-operation discards pending reads and busy marks.
  - First cycle after release: Rd_Valid = 0.
- Storage write: at posedge with WB_En = 1, reg[WB_Addr] <= WB_Data. There is no write-enable hold path beyond this.
- Hazard per source s (rs1, rs2): haz_s = Busy_Vec[s] && !(WB_En && WB_Addr == s).
  - A same-cycle writeback resolves the hazard.
- Stall = Rd_Req && (haz_rs1 || haz_rs2).
- Accept = Rd_Req && !Stall.
- Read latency:
  - On accept at edge N, at edge N+1 Rd_Valid = 1 and Rs*_Data = bypass(s).
  - bypass(s) = WB_Data if (WB_En && WB_Addr == s), else reg[s], both sampled in the accept cycle.
- Rd_Valid is a one-cycle pulse per accept; back-to-back accepts give continuous Rd_Valid.
- With no accept, Rd_Valid = 0 and Rs*_Data hold their last values.
- Rs1_Addr == Rs2_Addr is legal; both outputs get the same value.
- Scoreboard update, per edge:
  - Clear bit WB_Addr if WB_En.
  - Then set bit Issue_Dest if Issue_En.
  - Set wins on the same index (a new producer supersedes).
  - Issue_En to an already-busy register leaves it busy (single outstanding writer per register; the upstream protocol guarantees this).
- A read and an Issue_En in the same cycle see the pre-issue Busy_Vec, so an instruction never stalls on its own destination.
- Issue_En is independent of Rd_Req/Stall; decode drives Issue_En only in a cycle where its read is accepted.
- Address widths are exact; no out-of-range indices exist when NREG = 2^ADDR_W.

Decomposition:
- Shared core package holds:
  - DATA_W and NREG/ADDR_W constants;
  - the register-index type;
  - the reset value constant (0).
- One natural sub-module: reg_scoreboard (Busy_Vec set/clear logic plus the hazard compare per source). The storage array and bypass/output registers stay in reg_file_rd.

Test Plan:
- Reset: assert RST_N = 0 mid-stream with Busy_Vec = 4'b0110 and Rd_Valid = 1 -> all outputs 0 immediately; Rd_Valid stays 0 on the first edge after release.
- Basic read: WB R1 = 0x5A, R2 = 0xC3; next cycle Rd_Req with rs1 = 1, rs2 = 2 -> Stall = 0; one cycle later Rd_Valid = 1, Rs1_Data = 0x5A, Rs2_Data = 0xC3.
- RAW stall: Issue_En with dest = 3; next cycle Rd_Req with rs1 = 3 -> Stall = 1 each cycle until the WB_En, WB_Addr = 3, WB_Data = 0x7E cycle, where Stall = 0; next cycle Rs1_Data = 0x7E and Busy_Vec[3] = 0.
- Bypass, unbusy register: Rd_Req rs2 = 0 in the same cycle as WB_En, WB_Addr = 0, WB_Data = 0x11 -> Rs2_Data = 0x11 (not the old value).
- Scoreboard race: Issue_En dest = 2 and WB_En addr = 2 in the same cycle -> Busy_Vec[2] = 1 afterwards. Also, Rd_Req rs1 = 2 with Issue_En dest = 2 and R2 not busy -> no stall.
- Throughput: 4 consecutive accepted reads of R0..R3 (no busy registers) -> Rd_Valid high for 4 consecutive cycles with data matching the register contents in order.
